// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: decodes loads/stores, drives a req/ack data port, aligns store data and extends load data.
// Optional misaligned-access trap is built when MEM_MISALIGN_CHK_EN is defined.
module mem_stage_lsu #(
  parameter int addrWidth = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          inst,
  input  logic [31:0]          alu_out,
  input  logic [31:0]          rs2_rdata,
  output logic                 stall,
  output logic [31:0]          ld_data,
  output logic                 ld_valid,
  output logic                 misalign_err,
  output logic                 dm_req,
  output logic                 dm_we,
  output logic [addrWidth-1:0] dm_addr,
  output logic [3:0]           dm_wstrb,
  output logic [31:0]          dm_wdata,
  input  logic                 dm_ack,
  input  logic [31:0]          dm_rdata
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_e;

  state_e state_q, state_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [1:0] off;
  logic       is_load, is_store, misaligned, memop;

  logic [3:0]           wstrb_d;
  logic [31:0]          wdata_d;
  logic                 we_q;
  logic [addrWidth-1:0] addr_q;
  logic [3:0]           wstrb_q;
  logic [31:0]          wdata_q;
  logic [1:0]           off_q;
  logic [2:0]           funct3_q;
  logic [31:0]          ld_data_q, ld_ext;
  logic                 ld_valid_q;
  logic [7:0]           byte_lane;
  logic [15:0]          half_lane;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign off    = alu_out[1:0];

  // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    if (opcode == OP_LOAD)
      is_load = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    if (opcode == OP_STORE)
      is_store = funct3 inside {3'b000, 3'b001, 3'b010};
  end

`ifdef MEM_MISALIGN_CHK_EN
  // funct3[1:0] encodes access size for every legal load/store: 00 byte, 01 half, 10 word.
  assign misaligned = ((funct3[1:0] == 2'b01) && off[0]) ||
                      ((funct3[1:0] == 2'b10) && (off != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  assign memop = (is_load || is_store) && !misaligned;

  always_comb begin
    wstrb_d = 4'b0000;
    wdata_d = rs2_rdata;
    if (is_store) begin
      unique case (funct3[1:0])
        2'b00: begin
          wstrb_d = 4'b0001 << off;
          wdata_d = {4{rs2_rdata[7:0]}};
        end
        2'b01: begin
          wstrb_d = 4'b0011 << {off[1], 1'b0};
          wdata_d = {2{rs2_rdata[15:0]}};
        end
        default: wstrb_d = 4'b1111;
      endcase
    end
  end

  // Halfword lanes follow off[1] only; word loads ignore the offset entirely.
  assign byte_lane = dm_rdata[{off_q, 3'b000} +: 8];
  assign half_lane = dm_rdata[{off_q[1], 4'b0000} +: 16];

  always_comb begin
    ld_ext = dm_rdata;
    unique case (funct3_q)
      3'b000:  ld_ext = {{24{byte_lane[7]}}, byte_lane};
      3'b001:  ld_ext = {{16{half_lane[15]}}, half_lane};
      3'b100:  ld_ext = {24'b0, byte_lane};
      3'b101:  ld_ext = {16'b0, half_lane};
      default: ld_ext = dm_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (memop) begin
          state_d = S_WAIT;
          stall   = 1'b1;
        end
      end
      S_WAIT: begin
        stall = 1'b1;
        if (dm_ack) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wstrb_q    <= 4'b0000;
      wdata_q    <= '0;
      off_q      <= 2'b00;
      funct3_q   <= 3'b000;
      ld_data_q  <= '0;
      ld_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ld_valid_q <= 1'b0;
      if ((state_q == S_IDLE) && memop) begin
        we_q     <= is_store;
        addr_q   <= alu_out[addrWidth-1:0];
        wstrb_q  <= wstrb_d;
        wdata_q  <= wdata_d;
        off_q    <= off;
        funct3_q <= funct3;
      end
      if ((state_q == S_WAIT) && dm_ack && !we_q) begin
        ld_data_q  <= ld_ext;
        ld_valid_q <= 1'b1;
      end
    end
  end

`ifdef MEM_MISALIGN_CHK_EN
  logic [31:0] inst_q;
  logic        flag_q, flag_eff, mis_detect, mis_err_q;

  // The flag suppresses repeat errors while the same instruction sits in MEM.
  assign flag_eff   = flag_q && (inst == inst_q);
  assign mis_detect = (state_q == S_IDLE) && (is_load || is_store) && misaligned && !flag_eff;

  always_ff @(posedge clk) begin
    if (rst) begin
      inst_q    <= '0;
      flag_q    <= 1'b0;
      mis_err_q <= 1'b0;
    end else begin
      inst_q    <= inst;
      flag_q    <= flag_eff || mis_detect;
      mis_err_q <= mis_detect;
    end
  end

  assign misalign_err = mis_err_q;
`else
  assign misalign_err = 1'b0;
`endif

  assign dm_req   = (state_q == S_WAIT);
  assign dm_we    = we_q;
  assign dm_addr  = addr_q;
  assign dm_wstrb = wstrb_q;
  assign dm_wdata = wdata_q;
  assign ld_data  = ld_data_q;
  assign ld_valid = ld_valid_q;

  logic unused_ok;
  assign unused_ok = ^{inst[31:15], inst[11:7], alu_out[31:addrWidth]};

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: transaction-level model compared every cycle plus directed literal checks.
module tb_mem_stage_lsu;

  localparam logic [31:0] NOP     = 32'h00B50533;
  localparam logic [31:0] I_SW    = 32'h00B52023;
  localparam logic [31:0] I_SB    = 32'h00B50023;
  localparam logic [31:0] I_SH    = 32'h00B51023;
  localparam logic [31:0] I_LB    = 32'h00050583;
  localparam logic [31:0] I_LH    = 32'h00051583;
  localparam logic [31:0] I_LW    = 32'h00052583;
  localparam logic [31:0] I_LBU   = 32'h00054583;
  localparam logic [31:0] I_LHU   = 32'h00055583;
  localparam logic [31:0] I_BADLD = 32'h00053583;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst, alu_out, rs2_rdata, dm_rdata;
  logic        dm_ack;
  logic        stall, ld_valid, misalign_err, dm_req, dm_we;
  logic [31:0] ld_data, dm_wdata;
  logic [14:0] dm_addr;
  logic [3:0]  dm_wstrb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage_lsu #(.addrWidth(15)) dut (
    .clk(clk), .rst(rst), .inst(inst), .alu_out(alu_out), .rs2_rdata(rs2_rdata),
    .stall(stall), .ld_data(ld_data), .ld_valid(ld_valid), .misalign_err(misalign_err),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wstrb(dm_wstrb),
    .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit m_is_load(input logic [31:0] i);
    int f3 = int'(i[14:12]);
    return (i[6:0] == 7'h03) && (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
  endfunction

  function automatic bit m_is_store(input logic [31:0] i);
    return (i[6:0] == 7'h23) && (int'(i[14:12]) <= 2);
  endfunction

  function automatic int m_size(input logic [31:0] i);
    case (i[13:12])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit m_misaligned(input logic [31:0] i, input logic [31:0] a);
`ifdef MEM_MISALIGN_CHK_EN
    return (m_is_load(i) || m_is_store(i)) && ((a % m_size(i)) != 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit m_is_access(input logic [31:0] i, input logic [31:0] a);
    return (m_is_load(i) || m_is_store(i)) && !m_misaligned(i, a);
  endfunction

  function automatic logic [31:0] m_wstrb(input logic [31:0] i, input logic [31:0] a);
    if (!m_is_store(i)) return 32'd0;
    case (m_size(i))
      1:       return 32'd1 << (a % 4);
      2:       return 32'd3 << (((a % 4) / 2) * 2);
      default: return 32'd15;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(input logic [31:0] i, input logic [31:0] r);
    case (m_size(i))
      1:       return (r & 32'hFF) * 32'h01010101;
      2:       return (r & 32'hFFFF) * 32'h00010001;
      default: return r;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] i, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v;
    bit          sgn = (i[14] == 1'b0);
    case (m_size(i))
      1: begin
        v = (rd >> (8 * (a % 4))) & 32'hFF;
        if (sgn && v >= 128) v = v - 32'd256;
      end
      2: begin
        v = (rd >> (8 * (((a % 4) / 2) * 2))) & 32'hFFFF;
        if (sgn && v >= 32768) v = v - 32'd65536;
      end
      default: v = rd;
    endcase
    return v;
  endfunction

  bit          model_valid = 0;
  bit          m_out, m_fin, m_ldv, m_mis, m_flag;
  logic [31:0] m_ld, m_flag_inst, t_inst, t_addr, t_rs2;

  always @(posedge clk) begin
    if (rst) begin
      model_valid = 1; m_out = 0; m_fin = 0; m_ldv = 0; m_mis = 0; m_flag = 0; m_ld = '0;
    end else if (model_valid) begin
      bit idle = !m_out && !m_fin;
      m_ldv = 0;
      m_mis = 0;
      if (m_flag && inst != m_flag_inst) m_flag = 0;
      if (idle && m_misaligned(inst, alu_out) && !m_flag) begin
        m_mis = 1; m_flag = 1; m_flag_inst = inst;
      end
      if (m_fin) m_fin = 0;
      else if (m_out) begin
        if (dm_ack) begin
          m_out = 0; m_fin = 1;
          if (m_is_load(t_inst)) begin
            m_ld  = m_load(t_inst, t_addr, dm_rdata);
            m_ldv = 1;
          end
        end
      end else if (m_is_access(inst, alu_out)) begin
        m_out = 1; t_inst = inst; t_addr = alu_out; t_rs2 = rs2_rdata;
      end
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      check("stall", 32'(stall), 32'(m_out || (!m_fin && m_is_access(inst, alu_out))));
      check("dm_req", 32'(dm_req), 32'(m_out));
      if (m_out) begin
        check("dm_we", 32'(dm_we), 32'(m_is_store(t_inst)));
        check("dm_addr", 32'(dm_addr), t_addr & 32'h7FFF);
        check("dm_wstrb", 32'(dm_wstrb), m_wstrb(t_inst, t_addr));
        if (m_is_store(t_inst)) check("dm_wdata", dm_wdata, m_wdata(t_inst, t_rs2));
      end
      check("ld_valid", 32'(ld_valid), 32'(m_ldv));
      check("ld_data", ld_data, m_ld);
      check("misalign_err", 32'(misalign_err), 32'(m_mis));
    end
  end

  // ---------------- directed stimulus ----------------
  // Entered at #1 after a rising edge with the FSM idle; returns at #1 after the edge ending DONE with inst=NOP.
  task automatic do_access(input logic [31:0] i, input logic [31:0] a, input logic [31:0] r,
                           input logic [31:0] rd, input int ack_wait,
                           output int stalls, output bit ldv_seen, output logic [31:0] ld_done,
                           output logic [31:0] req_addr, output logic [31:0] req_strb,
                           output logic [31:0] req_wdata, output bit req_we);
    int waits = 0;
    bit timed_out = 1;
    inst = i; alu_out = a; rs2_rdata = r; dm_rdata = rd; dm_ack = 0;
    stalls = 0; ldv_seen = 0; ld_done = '0;
    req_addr = '0; req_strb = '0; req_wdata = '0; req_we = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (!stall) begin
        timed_out = 0;
        ldv_seen  = ld_valid;
        ld_done   = ld_data;
        break;
      end
      stalls++;
      if (dm_req) begin
        waits++;
        if (waits == 1) begin
          req_addr = 32'(dm_addr); req_strb = 32'(dm_wstrb); req_wdata = dm_wdata; req_we = dm_we;
        end
        if (waits == ack_wait) dm_ack = 1;
      end
      @(posedge clk); #1;
      dm_ack = 0;
    end
    check("ack_timeout", 32'(timed_out), 32'd0);
    @(posedge clk); #1;
    inst = NOP;
  endtask

  int          st;
  bit          lv, we;
  logic [31:0] ldd, ra, rs, rw;

  initial begin
    rst = 1; inst = NOP; alu_out = '0; rs2_rdata = '0; dm_rdata = '0; dm_ack = 0;
    repeat (2) @(posedge clk);
    #1; rst = 0;
    #1;
    check("rst_dm_req", 32'(dm_req), 32'd0);
    check("rst_ld_data", ld_data, 32'd0);
    check("rst_ld_valid", 32'(ld_valid), 32'd0);
    check("rst_misalign", 32'(misalign_err), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;

    do_access(I_SW, 32'h100, 32'hDEADBEEF, 32'h0, 1, st, lv, ldd, ra, rs, rw, we);
    check("sw_stalls", st, 2);
    check("sw_we", 32'(we), 32'd1);
    check("sw_addr", ra, 32'h100);
    check("sw_strb", rs, 32'hF);
    check("sw_wdata", rw, 32'hDEADBEEF);
    check("sw_no_ldv", 32'(lv), 32'd0);

    do_access(I_SB, 32'h103, 32'h000000A5, 32'h0, 1, st, lv, ldd, ra, rs, rw, we);
    check("sb_strb", rs, 32'h8);
    check("sb_wdata", rw, 32'hA5A5A5A5);
    check("sb_ld_keep", ldd, 32'h0);

    do_access(I_LB, 32'h102, 32'h12F03456, 32'h12F03456, 1, st, lv, ldd, ra, rs, rw, we);
    check("lb_data", ldd, 32'hFFFFFFF0);
    check("lb_ldv", 32'(lv), 32'd1);
    check("lb_strb", rs, 32'h0);

    do_access(I_LBU, 32'h102, 32'h0, 32'h12F03456, 1, st, lv, ldd, ra, rs, rw, we);
    check("lbu_data", ldd, 32'h000000F0);

    do_access(I_LH, 32'h202, 32'h0, 32'h80010000, 3, st, lv, ldd, ra, rs, rw, we);
    check("lh_stalls", st, 4);
    check("lh_data", ldd, 32'hFFFF8001);

    do_access(I_SH, 32'h202, 32'h1234ABCD, 32'h0, 2, st, lv, ldd, ra, rs, rw, we);
    check("sh_stalls", st, 3);
    check("sh_strb", rs, 32'hC);
    check("sh_wdata", rw, 32'hABCDABCD);
    check("sh_ld_keep", ldd, 32'hFFFF8001);

    do_access(I_LHU, 32'h200, 32'h0, 32'h8001FFFE, 1, st, lv, ldd, ra, rs, rw, we);
    check("lhu_data", ldd, 32'h0000FFFE);

`ifdef MEM_MISALIGN_CHK_EN
    inst = I_LW; alu_out = 32'h101; dm_rdata = 32'h11223344;
    #1;
    check("mis_lw_stall", 32'(stall), 32'd0);
    check("mis_lw_req", 32'(dm_req), 32'd0);
    @(posedge clk); #2;
    check("mis_lw_pulse", 32'(misalign_err), 32'd1);
    @(posedge clk); #2;
    check("mis_lw_once", 32'(misalign_err), 32'd0);
    check("mis_lw_req2", 32'(dm_req), 32'd0);
    @(posedge clk); #1;
    inst = I_SH; alu_out = 32'h203;
    @(posedge clk); #2;
    check("mis_sh_pulse", 32'(misalign_err), 32'd1);
    check("mis_ld_keep", ld_data, 32'h0000FFFE);
    @(posedge clk); #1;
    inst = NOP;
    @(posedge clk); #1;
`else
    do_access(I_LW, 32'h101, 32'h0, 32'h11223344, 1, st, lv, ldd, ra, rs, rw, we);
    check("lw_off_stalls", st, 2);
    check("lw_off_addr", ra, 32'h101);
    check("lw_off_data", ldd, 32'h11223344);
    do_access(I_SH, 32'h203, 32'h5555AAAA, 32'h0, 1, st, lv, ldd, ra, rs, rw, we);
    check("sh_off_strb", rs, 32'hC);
    check("sh_off_wdata", rw, 32'hAAAAAAAA);
`endif

    // Reset during the second WAIT cycle, ack arriving afterwards.
    inst = I_LW; alu_out = 32'h300; dm_rdata = 32'hCAFEF00D;
    @(posedge clk); #2;
    check("rw_req_w1", 32'(dm_req), 32'd1);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0; dm_ack = 1; inst = NOP;
    #1;
    check("rw_req_after_rst", 32'(dm_req), 32'd0);
    check("rw_ld_data", ld_data, 32'd0);
    @(posedge clk); #1;
    dm_ack = 0;
    #1;
    check("rw_ldv", 32'(ld_valid), 32'd0);
    check("rw_stall", 32'(stall), 32'd0);
    check("rw_req", 32'(dm_req), 32'd0);

    // Non-memory opcode and an illegal load funct3 are both no-ops.
    inst = NOP; alu_out = 32'h100;
    @(posedge clk); #2;
    check("nop_stall", 32'(stall), 32'd0);
    check("nop_req", 32'(dm_req), 32'd0);
    @(posedge clk); #1;
    inst = I_BADLD;
    #1;
    check("badld_stall", 32'(stall), 32'd0);
    @(posedge clk); #2;
    check("badld_req", 32'(dm_req), 32'd0);
    @(posedge clk); #1;
    inst = NOP;
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
